// File: rtl/kpg_pkg.sv
// Shared KPG code types, combine rule and pipeline sizing for the prefix adder.
package kpg_pkg;

    typedef logic [1:0] kpg_t;

    localparam kpg_t KPG_KILL = 2'b00;
    localparam kpg_t KPG_PROP = 2'b01;
    localparam kpg_t KPG_GEN  = 2'b10;

    // hi wins unless it propagates; the illegal 11 code behaves as GEN
    function automatic kpg_t kpg_combine(input kpg_t hi, input kpg_t lo);
        kpg_t r;
        if (hi == KPG_PROP) begin
            r = lo;
        end else if (hi == KPG_KILL) begin
            r = KPG_KILL;
        end else begin
            r = KPG_GEN;
        end
        return r;
    endfunction

    function automatic int unsigned kpg_ngrp(input int unsigned width, input int unsigned reg_every);
        int unsigned lvls;
        lvls = $clog2(width);
        return (lvls + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/kpg_prefix_adder_pipe_cell.sv
// Single KPG combine cell of the prefix network.
module kpg_cell
    import kpg_pkg::*;
(
    input  kpg_t hi,
    input  kpg_t lo,
    output kpg_t y
);

    assign y = kpg_combine(hi, lo);

endmodule

// File: rtl/kpg_prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a combinational valid/ready chain.
module kpg_prefix_adder_pipe
    import kpg_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned REG_EVERY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned L    = $clog2(WIDTH);
    localparam int unsigned NGRP = kpg_ngrp(WIDTH, REG_EVERY);
    // code stages 0..NGRP plus the output register
    localparam int unsigned NSTG = NGRP + 2;

    logic [NSTG-1:0]  v;
    logic [NSTG:0]    rdy;
    logic [NSTG-1:0]  vin;

    // Index 0 is the virtual carry-in bit; index i+1 is operand bit i
    kpg_t [WIDTH:0]   code_q [NGRP+1];
    logic [WIDTH-1:0] p_q    [NGRP+1];
    logic [NGRP:0]    am_q;
    logic [NGRP:0]    bm_q;
    kpg_t [WIDTH:0]   grp_out [NGRP];

    logic [WIDTH-1:0] bi;
    kpg_t [WIDTH:0]   code_in;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_nxt;
    kpg_t             top_code;
    logic             ovf_nxt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // Ready ripples back from the sink; an empty stage always accepts
    always_comb begin
        rdy       = '0;
        rdy[NSTG] = out_ready;
        for (int s = int'(NSTG) - 1; s >= 0; s--) begin
            rdy[s] = ~v[s] | rdy[s+1];
        end
    end

    assign vin       = {v[NSTG-2:0], in_valid};
    assign in_ready  = rdy[0];
    assign out_valid = v[NSTG-1];
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_comb begin
        bi         = b ^ {WIDTH{sub}};
        code_in    = '0;
        code_in[0] = (sub | cin) ? KPG_GEN : KPG_KILL;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (a[i] & bi[i]) begin
                code_in[i+1] = KPG_GEN;
            end else if (a[i] ^ bi[i]) begin
                code_in[i+1] = KPG_PROP;
            end else begin
                code_in[i+1] = KPG_KILL;
            end
        end
    end

    for (genvar g = 0; g < int'(NGRP); g++) begin : grp
        for (genvar m = 0; m < int'(REG_EVERY); m++) begin : lvl
            localparam int unsigned K = g * REG_EVERY + m;
            kpg_t [WIDTH:0] lin;
            kpg_t [WIDTH:0] lout;
            if (m == 0) begin : src_reg
                assign lin = code_q[g];
            end else begin : src_lvl
                assign lin = lvl[m-1].lout;
            end
            for (genvar j = 0; j <= int'(WIDTH); j++) begin : pos
                if (K < L && j >= (1 << K)) begin : cmb
                    kpg_cell u_cell (
                        .hi (lin[j]),
                        .lo (lin[j-(1<<K)]),
                        .y  (lout[j])
                    );
                end else begin : pass
                    assign lout[j] = lin[j];
                end
            end
        end
        assign grp_out[g] = lvl[REG_EVERY-1].lout;

        always_ff @(posedge clk) begin
            if (v[g] && rdy[g+1]) begin
                code_q[g+1] <= grp_out[g];
                p_q[g+1]    <= p_q[g];
                am_q[g+1]   <= am_q[g];
                bm_q[g+1]   <= bm_q[g];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && rdy[0]) begin
            code_q[0] <= code_in;
            p_q[0]    <= a ^ bi;
            am_q[0]   <= a[WIDTH-1];
            bm_q[0]   <= bi[WIDTH-1];
        end
    end

    // Position WIDTH spans bits 0..WIDTH-1 only, so fold the virtual bit in for cout
    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            carry[i] = code_q[NGRP][i][1];
        end
        sum_nxt  = p_q[NGRP] ^ carry;
        top_code = kpg_combine(code_q[NGRP][WIDTH], code_q[NGRP][0]);
        ovf_nxt  = (am_q[NGRP] == bm_q[NGRP]) & (sum_nxt[WIDTH-1] != am_q[NGRP]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v      <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            v <= (vin & rdy[NSTG-1:0]) | (v & ~rdy[NSTG-1:0]);
            if (rdy[NSTG-1] && v[NSTG-2]) begin
                sum_q  <= sum_nxt;
                cout_q <= top_code[1];
                ovf_q  <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_kpg_prefix_adder_pipe.sv
// Scoreboard bench for kpg_prefix_adder_pipe at WIDTH=16, REG_EVERY=1.
module tb_kpg_prefix_adder_pipe;

    localparam int unsigned W = 16;
    localparam int LAT   = 5;
    localparam int DEPTH = 6;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    res_t q[$];
    res_t mon_e;
    int   n_run  = 0;
    int   n_fail = 0;
    int   seen   = 0;

    kpg_prefix_adder_pipe #(.WIDTH(W), .REG_EVERY(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference via signed/unsigned integer arithmetic
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input logic c);
        res_t   r;
        longint ux, uy, ut, sx, sy, st;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            ut = ux + ((64'd1 << W) - 1 - uy) + 1;
            st = sx - sy;
        end else begin
            ut = ux + uy + longint'(c);
            st = sx + sy + longint'(c);
        end
        r.s = W'(ut);
        r.c = ut[W];
        r.o = (st > (64'sd1 <<< (W-1)) - 1) || (st < -(64'sd1 <<< (W-1)));
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (in_valid && in_ready) q.push_back(model(a, b, sub, cin));
            if (out_valid) seen++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("result", {sum, cout, ovf}, mon_e);
                end
            end
        end
    end

    task automatic step(input logic iv, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xs, input logic xc, input logic ordy, output logic acc);
        in_valid  = iv;
        a         = xa;
        b         = xb;
        sub       = xs;
        cin       = xc;
        out_ready = ordy;
        @(negedge clk);
        acc = iv & in_ready;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] va [4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [W-1:0] vb [4] = '{16'h0000, 16'h0001, 16'h0007, 16'h0001};
    logic         vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic         vc [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        logic acc;
        int   cnt;
        int   cyc;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic add and first-beat latency
        step(1, 16'h1234, 16'h0FF0, 0, 0, 1, acc);
        chk("basic_accept", acc, 1);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, LAT);
        chk("basic_sum", {sum, cout, ovf}, {16'h2224, 1'b0, 1'b0});

        // Carry chain, overflow and subtract corners back to back
        for (int k = 0; k < 4; k++) step(1, va[k], vb[k], vs[k], vc[k], 1, acc);
        repeat (8) step(0, '0, '0, 0, 0, 1, acc);
        chk("corners_drained", q.size(), 0);

        // Fill a stalled pipe until in_ready drops
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0, acc);
            if (!acc) break;
            cnt++;
        end
        chk("bp_depth", cnt, DEPTH);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        repeat (3) step(0, '0, '0, 0, 0, 0, acc);
        chk("bp_hold", {sum, cout, ovf}, q[0]);
        chk("bp_still_full", in_ready, 0);
        repeat (10) step(0, '0, '0, 0, 0, 1, acc);
        chk("bp_drained", q.size(), 0);

        // Full pipe: pop and push on the same edge
        for (int k = 0; k < DEPTH; k++) step(1, W'($urandom), W'($urandom), 0, 1'($urandom), 0, acc);
        step(1, 16'h00FF, 16'h0001, 0, 0, 1, acc);
        chk("full_pass_accept", acc, 1);
        chk("full_no_bubble", out_valid, 1);
        repeat (10) step(0, '0, '0, 0, 0, 1, acc);
        chk("full_drained", q.size(), 0);

        // Reset with beats in flight
        for (int k = 0; k < 3; k++) step(1, 16'h1111 * 16'(k + 1), 16'h0101, 0, 0, 0, acc);
        repeat (6) step(0, '0, '0, 0, 0, 0, acc);
        chk("pre_rst_valid", out_valid, 1);
        #3 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_in_ready", in_ready, 1);
        q.delete();
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (12) step(0, '0, '0, 0, 0, 1, acc);
        chk("post_rst_none", seen, 0);

        // Random traffic with random back-pressure
        cnt = 0;
        cyc = 0;
        while (cnt < 3000 && cyc < 20000) begin
            step(($urandom % 4) != 0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom % 4) != 0, acc);
            if (acc) cnt++;
            cyc++;
        end
        chk("rand_beats", cnt, 3000);
        cyc = 0;
        while (q.size() > 0 && cyc < 200) begin
            step(0, '0, '0, 0, 0, 1, acc);
            cyc++;
        end
        chk("rand_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
